// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared ibus/fetch types, reset PC and kseg0/kseg1 translation.
package fetch_queue_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'hbfc0_0000;
  localparam logic [31:0] KSEG_MASK = 32'h1fff_ffff;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  typedef struct packed {
    logic [31:0] pc;
    logic        kill;
  } fetch_tag_t;
  function automatic logic [31:0] kseg_xlate(input logic [31:0] va);
    return (va[31:30] == 2'b10) ? (va & KSEG_MASK) : va;
  endfunction
endpackage

// File: rtl/fetch_queue_fifo.sv
// fetch_fifo: circular FIFO with occupancy count and synchronous clear.
module fetch_fifo #(
  parameter int W = 32,
  parameter int N = 4,
  localparam int AW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  input  logic          clear_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0] mem_q [N];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(N - 1)) ? '0 : p + 1'b1;
  endfunction
  assign do_pop = pop_i && cnt_q != '0;
  assign dout_o = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= push_i ? nxt(wr_q) : wr_q;
      rd_q <= do_pop ? nxt(rd_q) : rd_q;
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (push_i && !clear_i) mem_q[wr_q] <= din_i;
  // Callers size their credits so a push never lands on a full FIFO.
  always_ff @(posedge clk)
    if (resetn && push_i && !do_pop && !clear_i) assert (cnt_q != CW'(N));
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: pipelined ibus fetch with a PC/instr queue and redirect kill of in-flight requests.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  localparam int QA = $clog2(DEPTH);
  localparam int TA = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  logic [31:0] fetch_pc_q, fetch_pc_d, redir_pc_q, redir_pc_d, tpc;
  logic defer_q, defer_d, pend_q, run_q, credit, acc, rsp, keep, qpush;
  logic [MAX_OUTSTANDING-1:0] kill_q, kill_d;
  logic [QA:0] qcnt;
  logic [TA:0] tcnt;
  logic [TA-1:0] tidx;
  fetch_tag_t head;
  fetch_entry_t qin, qhead;
  assign credit = run_q && int'(tcnt) < MAX_OUTSTANDING && int'(qcnt) + int'(tcnt) < DEPTH;
  assign ireq.valid = pend_q || credit;
  assign ireq.addr = kseg_xlate(fetch_pc_q & ~32'h3);
  assign acc = ireq.valid && iresp.addr_ok;
  assign rsp = iresp.data_ok && tcnt != '0;
  assign head = '{pc: tpc, kill: kill_q[0]};
  assign keep = rsp && !head.kill && !redirect_valid;
  assign qin = '{pc: head.pc, instr: iresp.data};
  assign tidx = TA'(tcnt - (TA + 1)'(rsp));
`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp;
  assign byp = keep && qcnt == '0;
  assign qpush = keep && !(byp && out_ready);
  assign out_valid = qcnt != '0 || byp;
  assign out_pc = qcnt != '0 ? qhead.pc : byp ? head.pc : '0;
  assign out_instr = qcnt != '0 ? qhead.instr : byp ? iresp.data : '0;
`else
  assign qpush = keep;
  assign out_valid = qcnt != '0;
  assign out_pc = out_valid ? qhead.pc : '0;
  assign out_instr = out_valid ? qhead.instr : '0;
`endif
  // Kill bits are kept in age order (bit 0 = oldest in flight), so a pop is a shift.
  always_comb begin
    defer_d = defer_q;
    redir_pc_d = redir_pc_q;
    fetch_pc_d = fetch_pc_q;
    kill_d = rsp ? kill_q >> 1 : kill_q;
    if (acc) begin
      kill_d[tidx] = redirect_valid || defer_q;
      fetch_pc_d = defer_q ? redir_pc_q : fetch_pc_q + 32'd4;
      defer_d = 1'b0;
    end
    if (redirect_valid) begin
      kill_d = '1;
      if (ireq.valid && !iresp.addr_ok) begin
        defer_d = 1'b1;
        redir_pc_d = redirect_pc & ~32'h3;
      end else fetch_pc_d = redirect_pc & ~32'h3;
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      fetch_pc_q <= RESET_PC;
      redir_pc_q <= '0;
      defer_q <= 1'b0;
      pend_q <= 1'b0;
      run_q <= 1'b0;
      kill_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      redir_pc_q <= redir_pc_d;
      defer_q <= defer_d;
      pend_q <= ireq.valid && !iresp.addr_ok;
      run_q <= 1'b1;
      kill_q <= kill_d;
    end
  fetch_fifo #(.W(32), .N(MAX_OUTSTANDING)) u_tag (
    .clk(clk), .resetn(resetn), .push_i(acc), .din_i(fetch_pc_q), .pop_i(rsp),
    .clear_i(1'b0), .dout_o(tpc), .count_o(tcnt)
  );
  fetch_fifo #(.W($bits(fetch_entry_t)), .N(DEPTH)) u_queue (
    .clk(clk), .resetn(resetn), .push_i(qpush), .din_i(qin), .pop_i(out_ready),
    .clear_i(redirect_valid), .dout_o(qhead), .count_o(qcnt)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized bench; decode must see the program-order stream restarted by each redirect.
`timescale 1ns/1ps
module tb_fetch_queue;
  import fetch_queue_pkg::*;
  localparam int DEPTH = 4;
  localparam int MAXO = 2;
  localparam logic [31:0] RPC = 32'hbfc0_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, resetn = 1'b0;
  ibus_req_t ireq;
  ibus_resp_t iresp = '0;
  logic out_valid, out_ready = 1'b0, redirect_valid = 1'b0;
  logic [31:0] out_pc, out_instr, redirect_pc = '0;
  int n_chk = 0, n_pass = 0, n_hs = 0;
  int p_aok, p_dok, p_rdy, p_redir;
  bit use_fix = 1'b0, prev_pend = 1'b0;
  logic [31:0] fix_pc, exp_pc = RPC, prev_addr;
  logic [31:0] slv[$];
  logic [31:0] acc_log[$];

  fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
    .clk(clk), .resetn(resetn), .ireq(ireq), .iresp(iresp), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] phys(input logic [31:0] va);
    if (va >= 32'h8000_0000 && va < 32'ha000_0000) return va - 32'h8000_0000;
    if (va >= 32'ha000_0000 && va < 32'hc000_0000) return va - 32'ha000_0000;
    return va;
  endfunction

  function automatic logic [31:0] word(input logic [31:0] pa);
    return (pa * 32'h9e37_79b1) ^ 32'h2408_0001;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [15:0] lo = 16'($urandom);
    case ($urandom_range(2))
      0: return {16'h8000, lo};
      1: return {16'hbfc0, lo};
      default: return {16'h0040, lo};
    endcase
  endfunction

  task automatic step();
    @(negedge clk);
    out_ready = $urandom_range(99) < p_rdy;
    iresp.addr_ok = $urandom_range(99) < p_aok;
    iresp.data_ok = 1'b0;
    iresp.data = $urandom;
    if (slv.size() > 0) begin
      iresp.data_ok = $urandom_range(99) < p_dok;
      iresp.data = word(slv[0]);
    end
    redirect_valid = $urandom_range(99) < p_redir;
    redirect_pc = use_fix ? fix_pc : rand_pc();
    #1;
    if (prev_pend) begin
      chk("hold_valid", 32'(ireq.valid), 32'd1);
      chk("hold_addr", ireq.addr, prev_addr);
    end
    if (out_valid && out_ready) begin
      chk("out_pc", out_pc, exp_pc);
      chk("out_instr", out_instr, word(phys(exp_pc)));
      exp_pc += 4;
      n_hs++;
    end
    if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
    if (iresp.data_ok) void'(slv.pop_front());
    if (ireq.valid && iresp.addr_ok) begin
      slv.push_back(ireq.addr);
      acc_log.push_back(ireq.addr);
    end
    chk("outstanding_le_max", 32'(slv.size() <= MAXO), 32'd1);
    prev_pend = ireq.valid && !iresp.addr_ok;
    prev_addr = ireq.addr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    out_ready = 1'b0;
    iresp = '0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_ireq_valid", 32'(ireq.valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    slv.delete();
    acc_log.delete();
    exp_pc = RPC;
    prev_pend = 1'b0;
    n_hs = 0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic knobs(input int a, input int d, input int r, input int x);
    p_aok = a;
    p_dok = d;
    p_rdy = r;
    p_redir = x;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    knobs(100, 100, 100, 0);
    repeat (8) step();
    chk("seq_addr0", acc_log[0], 32'h1fc0_0000);
    chk("seq_addr1", acc_log[1], 32'h1fc0_0004);
    chk("seq_fill_rate", 32'(n_hs >= 4), 32'd1);

    do_reset();
    knobs(100, 100, 0, 0);
    repeat (12) step();
    chk("stall_accepts", 32'(acc_log.size()), 32'(DEPTH));
    chk("stall_ireq_valid", 32'(ireq.valid), 32'd0);
    chk("stall_head_pc", out_pc, RPC);
    knobs(100, 100, 100, 0);
    step();
    step();
    chk("resume_ireq_valid", 32'(ireq.valid), 32'd1);
    chk("resume_popped", 32'(n_hs >= 1), 32'd1);

    do_reset();
    knobs(100, 0, 100, 0);
    repeat (3) step();
    chk("two_inflight", 32'(acc_log.size()), 32'd2);
    use_fix = 1'b1;
    fix_pc = 32'hbfc0_0100;
    knobs(100, 0, 100, 100);
    step();
    knobs(100, 100, 100, 0);
    repeat (8) step();
    chk("redir_next_addr", acc_log[2], 32'h1fc0_0100);
    chk("redir_progress", 32'(n_hs >= 2), 32'd1);

    do_reset();
    knobs(0, 100, 100, 0);
    repeat (4) step();
    chk("noack_accepts", 32'(acc_log.size()), 32'd0);
    fix_pc = 32'hbfc0_0200;
    knobs(0, 100, 100, 100);
    step();
    knobs(100, 100, 100, 0);
    repeat (8) step();
    chk("defer_old_addr", acc_log[0], 32'h1fc0_0000);
    chk("defer_new_addr", acc_log[1], 32'h1fc0_0200);
    chk("defer_progress", 32'(n_hs >= 2), 32'd1);
    use_fix = 1'b0;

    do_reset();
    knobs(100, 0, 0, 0);
    step();
    knobs(0, 100, 0, 0);
    step();
    chk("lat_same_valid", 32'(out_valid), 32'(BYP));
    chk("lat_same_instr", out_instr, BYP ? word(32'h1fc0_0000) : 32'd0);
    knobs(0, 0, 0, 0);
    step();
    chk("lat_next_valid", 32'(out_valid), 32'd1);
    chk("lat_next_instr", out_instr, word(32'h1fc0_0000));

    do_reset();
    knobs(70, 60, 70, 5);
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step();
    end
    chk("random_progress", 32'(n_hs > 300), 32'd1);

    knobs(100, 100, 100, 0);
    n_hs = 0;
    repeat (20) step();
    chk("drain_progress", 32'(n_hs > 0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
